block_sync_rx: RTL and testbench
================================

// Module: block_sync_rx
// PURPOSE
//  Per-lane 64b/66b block lock FSM (IEEE 802.3 cl.49/82 block sync) on the PCS receive path.
//  Sits between gearbox_rx and the descrambler/alignment-marker lock.
//  - Inspects the 2-bit sync header of every received block.
//  - Pulses slip_v_o so gearbox_rx shifts its block boundary by one bit.
//  - Raises lock_v_o once the boundary is stable.
//  One instance per lane: 1 lane for 10GBASE-R, 4 lanes for 40GBASE-R.
// PARAMETERS
//  HEAD_W        2   sync header width; only 2 is supported.
//  SH_CNT_MAX    64  headers per test window.
//  SH_INVLD_MAX  16  invalid headers per window that break lock.
//  SLIP_WAIT_N   1   valid headers discarded after each slip while the gearbox realigns (>=1).
// PORTS
//  clk       in   1       PCS clock
//  nreset    in   1       asynchronous active-low reset
//  valid_i   in   1       head_i carries a new block header this cycle
//  head_i    in   HEAD_W  sync header of the current block
//  slip_v_o  out  1       one-cycle request to gearbox_rx to slip by 1 bit
//  lock_v_o  out  1       block lock acquired
// BEHAVIOUR
//  Reset and outputs
//  - Reset (async, nreset=0): lock_v_o=0, slip_v_o=0, state=TEST, sh_cnt=0, invld_cnt=0, wait_cnt=0.
//  - Both outputs are registered: each responds on the cycle after the header that triggers it.
//  Header classification and gating
//  - sh_valid = (head_i==2'b01) | (head_i==2'b10); 2'b00 and 2'b11 are invalid.
//  - Nothing changes on cycles with valid_i=0. Counters advance only on valid_i=1.
//  - Counter widths: sh_cnt is $clog2(SH_CNT_MAX+1) bits; invld_cnt is $clog2(SH_INVLD_MAX+1) bits. Neither wraps.
//  - "reset counts" means sh_cnt=0 and invld_cnt=0.
//  States
//  - TEST, lock_v_o=0, on each valid header:
//    - invalid -> slip_v_o=1 for one cycle, reset counts, wait_cnt=SLIP_WAIT_N, go to WAIT.
//    - valid and sh_cnt+1==SH_CNT_MAX -> lock_v_o=1, reset counts, go to LOCKED.
//    - otherwise sh_cnt++.
//  - LOCKED, on each valid header:
//    - sh_cnt++, and invld_cnt++ if the header is invalid.
//    - if the updated invld_cnt==SH_INVLD_MAX -> lock_v_o=0, slip_v_o=1, reset counts, wait_cnt=SLIP_WAIT_N, go to WAIT.
//    - else if the updated sh_cnt==SH_CNT_MAX -> reset counts (window end), stay LOCKED.
//  - WAIT, on each valid header: the header is discarded and wait_cnt--. When wait_cnt reaches 0, go to TEST.
//    slip_v_o stays 0 in WAIT.
//  Priorities and boundary cases
//  - Loss of lock beats window end: if the 64th header is also the 16th invalid one, drop lock and slip.
//  - In TEST, an invalid 64th header slips; it does not lock.
//  - slip_v_o is never asserted on two consecutive valid headers, because WAIT always separates slips.
//  - nreset mid-window aborts immediately. A full clean window of SH_CNT_MAX valid headers is needed to relock.
//  - valid_i is don't-care only while nreset=0. head_i is ignored when valid_i=0.
// TESTING
//  1. After reset, 64 headers of 2'b01 with valid_i=1 every cycle
//     -> lock_v_o=1 on the cycle after the 64th; slip_v_o stays 0 throughout.
//  2. Unlocked: 10x 2'b10, then 2'b00
//     -> slip_v_o=1 for exactly one cycle; the next header (2'b11) is ignored;
//        64 further 2'b01 -> lock_v_o=1.
//  3. Locked: 15 headers of 2'b11 spread in a 64-header window, then a fresh window with 15 more
//     -> lock_v_o stays 1, slip_v_o stays 0; counters clear at each 64th header.
//  4. Locked: headers 1..16 of a window are 2'b00
//     -> on the cycle after the 16th, lock_v_o=0 and slip_v_o=1 (one-cycle pulse).
//  5. Acquisition with valid_i=0 gaps (random 0-3 idle cycles between headers)
//     -> lock_v_o rises after exactly 64 valid samples.
//  6. Locked, then nreset pulsed low mid-window
//     -> lock_v_o=0 asynchronously; relock only after 64 new valid headers.
//     Also: 63 valid headers then the 64th 2'b11 while unlocked -> slip, no lock.

Source files
------------

// File: rtl/block_sync_rx.sv
// ---------------------------------------------------------------------------
// block_sync_rx
//   Per-lane 64b/66b block lock state machine on the PCS receive path.
//   Sits between gearbox_rx and the descrambler / alignment-marker lock.
//   Every received block's 2-bit sync header is classified as valid (01/10)
//   or invalid (00/11). While hunting, a single invalid header asks the
//   gearbox to slip one bit. Once SH_CNT_MAX clean headers arrive in a row,
//   lock is declared. While locked, SH_INVLD_MAX invalid headers within one
//   SH_CNT_MAX window drop lock and request a slip.
//
// Ports
//   clk        in   1       PCS clock
//   nreset     in   1       asynchronous active-low reset
//   valid_i    in   1       head_i carries a new block header this cycle
//   head_i     in   HEAD_W  sync header of the current block
//   slip_v_o   out  1       one-cycle request to gearbox_rx to slip by 1 bit
//   lock_v_o   out  1       block lock acquired
//   state_dbg  out  2       current FSM state (0=TEST, 1=LOCKED, 2=WAIT)
//
// Handshake: there is no back-pressure. A header is consumed on every rising
//   clk edge where valid_i=1. Both outputs are registered, so they reflect
//   the header seen on the previous valid cycle. slip_v_o is a single-cycle
//   pulse, even if valid_i drops on the next cycle.
// ---------------------------------------------------------------------------
module block_sync_rx #(
   parameter int HEAD_W       = 2,
   parameter int SH_CNT_MAX   = 64,
   parameter int SH_INVLD_MAX = 16,
   parameter int SLIP_WAIT_N  = 1
) (
   input  logic              clk,
   input  logic              nreset,
   input  logic              valid_i,
   input  logic [HEAD_W-1:0] head_i,
   output logic              slip_v_o,
   output logic              lock_v_o,
   output logic [1:0]        state_dbg
);

   localparam int SH_W   = $clog2(SH_CNT_MAX + 1);
   localparam int INV_W  = $clog2(SH_INVLD_MAX + 1);
   localparam int WAIT_W = $clog2(SLIP_WAIT_N + 1);

   localparam logic [SH_W-1:0]   SH_LAST   = SH_W'(SH_CNT_MAX);
   localparam logic [INV_W-1:0]  INV_LAST  = INV_W'(SH_INVLD_MAX);
   localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(SLIP_WAIT_N);

   typedef enum logic [1:0] {
      ST_TEST   = 2'd0,
      ST_LOCKED = 2'd1,
      ST_WAIT   = 2'd2
   } state_t;

   state_t              state, state_nxt;
   logic [SH_W-1:0]     sh_cnt, sh_cnt_nxt;
   logic [INV_W-1:0]    invld_cnt, invld_cnt_nxt;
   logic [WAIT_W-1:0]   wait_cnt, wait_cnt_nxt;
   logic                slip_nxt, lock_nxt;

   logic                sh_valid;
   logic [SH_W-1:0]     sh_inc;
   logic [INV_W-1:0]    inv_inc;

   assign sh_valid = (head_i == HEAD_W'(1)) | (head_i == HEAD_W'(2));

   // Candidate counter values for the current header; the comparisons
   // below look at the post-increment count so the 64th / 16th header
   // itself triggers the decision.
   assign sh_inc  = sh_cnt + SH_W'(1);
   assign inv_inc = invld_cnt + {{(INV_W-1){1'b0}}, ~sh_valid};

   assign state_dbg = state;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state     <= ST_TEST;
         sh_cnt    <= '0;
         invld_cnt <= '0;
         wait_cnt  <= '0;
         slip_v_o  <= 1'b0;
         lock_v_o  <= 1'b0;
      end else begin
         state     <= state_nxt;
         sh_cnt    <= sh_cnt_nxt;
         invld_cnt <= invld_cnt_nxt;
         wait_cnt  <= wait_cnt_nxt;
         slip_v_o  <= slip_nxt;
         lock_v_o  <= lock_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      sh_cnt_nxt    = sh_cnt;
      invld_cnt_nxt = invld_cnt;
      wait_cnt_nxt  = wait_cnt;
      slip_nxt      = 1'b0;       // slip is a pulse, never held
      lock_nxt      = lock_v_o;

      if (valid_i) begin
         case (state)
            ST_TEST: begin
               if (!sh_valid) begin
                  // Invalid header beats a completed window: slip, no lock.
                  slip_nxt      = 1'b1;
                  sh_cnt_nxt    = '0;
                  invld_cnt_nxt = '0;
                  wait_cnt_nxt  = WAIT_INIT;
                  state_nxt     = ST_WAIT;
               end else if (sh_inc == SH_LAST) begin
                  lock_nxt      = 1'b1;
                  sh_cnt_nxt    = '0;
                  invld_cnt_nxt = '0;
                  state_nxt     = ST_LOCKED;
               end else begin
                  sh_cnt_nxt    = sh_inc;
               end
            end

            ST_LOCKED: begin
               // Loss of lock is checked first so it wins over window end.
               if (inv_inc == INV_LAST) begin
                  lock_nxt      = 1'b0;
                  slip_nxt      = 1'b1;
                  sh_cnt_nxt    = '0;
                  invld_cnt_nxt = '0;
                  wait_cnt_nxt  = WAIT_INIT;
                  state_nxt     = ST_WAIT;
               end else if (sh_inc == SH_LAST) begin
                  sh_cnt_nxt    = '0;
                  invld_cnt_nxt = '0;
               end else begin
                  sh_cnt_nxt    = sh_inc;
                  invld_cnt_nxt = inv_inc;
               end
            end

            ST_WAIT: begin
               // Headers here belong to the old alignment; drop them while
               // the gearbox settles on the new boundary.
               wait_cnt_nxt = wait_cnt - WAIT_W'(1);
               if (wait_cnt <= WAIT_W'(1)) begin
                  wait_cnt_nxt = '0;
                  state_nxt    = ST_TEST;
               end
            end

            default: begin
               state_nxt     = ST_TEST;
               sh_cnt_nxt    = '0;
               invld_cnt_nxt = '0;
               wait_cnt_nxt  = '0;
               lock_nxt      = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_block_sync_rx.sv
// ---------------------------------------------------------------------------
// tb_block_sync_rx
//   Directed bench for block_sync_rx. Each header sent carries its expected
//   {lock_v_o, slip_v_o} response, which is queued. The monitor pops one
//   entry per valid header and compares the registered outputs one cycle
//   later. On idle or reset cycles, it checks that slip is low and that lock
//   holds its last expected value.
// ---------------------------------------------------------------------------
module tb_block_sync_rx;

   logic       clk = 1'b0;
   logic       nreset = 1'b0;
   logic       valid_i = 1'b0;
   logic [1:0] head_i = 2'b00;
   logic       slip_v_o;
   logic       lock_v_o;
   logic [1:0] state_dbg;

   logic [1:0] exp_q[$];
   int         errors = 0;
   int         checks = 0;
   logic       last_lock = 1'b0;

   block_sync_rx dut (
      .clk       (clk),
      .nreset    (nreset),
      .valid_i   (valid_i),
      .head_i    (head_i),
      .slip_v_o  (slip_v_o),
      .lock_v_o  (lock_v_o),
      .state_dbg (state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got lock,slip=%b required %b at %0t", name, act, exp, $time);
      end
   endtask

   // driver tasks
   task automatic send(input logic [1:0] h, input logic el, input logic es);
      @(negedge clk);
      valid_i = 1'b1;
      head_i  = h;
      exp_q.push_back({el, es});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         valid_i = 1'b0;
         head_i  = 2'b11;   // must be ignored while valid_i=0
      end
   endtask

   task automatic do_reset();
      idle(1);
      @(negedge clk);
      #2 nreset = 1'b0;
      #1 check("async_reset", {lock_v_o, slip_v_o}, 2'b00);
      @(negedge clk);
      @(negedge clk);
      #2 nreset = 1'b1;
   endtask

   // scoreboard monitor
   initial begin
      logic       v;
      logic       r;
      logic [1:0] e;
      forever begin
         @(posedge clk);
         v = valid_i;
         r = nreset;
         @(negedge clk);
         if (!r) begin
            last_lock = 1'b0;
            check("in_reset", {lock_v_o, slip_v_o}, 2'b00);
         end else if (v) begin
            if (exp_q.size() == 0) begin
               errors++;
               checks++;
               $display("FAIL underflow: output with no expected entry at %0t", $time);
            end else begin
               e = exp_q.pop_front();
               last_lock = e[1];
               check("header_resp", {lock_v_o, slip_v_o}, e);
            end
         end else begin
            check("idle_hold", {lock_v_o, slip_v_o}, {last_lock, 1'b0});
         end
      end
   end

   // stimulus
   initial begin
      repeat (3) @(negedge clk);
      nreset = 1'b1;
      #1 check("reset_state", {lock_v_o, slip_v_o}, 2'b00);

      // 1: 64 clean headers lock on the 64th
      for (int i = 0; i < 64; i++) send(2'b01, (i == 63), 1'b0);

      // 2: unlocked, invalid header slips, next header discarded, relock
      do_reset();
      for (int i = 0; i < 10; i++) send(2'b10, 1'b0, 1'b0);
      send(2'b00, 1'b0, 1'b1);
      send(2'b11, 1'b0, 1'b0);
      for (int i = 0; i < 64; i++) send(2'b01, (i == 63), 1'b0);

      // 3: two windows of 15 invalid each keep lock
      for (int w = 0; w < 2; w++)
         for (int i = 0; i < 64; i++)
            send((i % 4 == 0 && i < 60) ? 2'b11 : 2'b01, 1'b1, 1'b0);

      // 4: 16 invalid at window start lose lock with a slip
      for (int i = 0; i < 16; i++) send(2'b00, (i != 15), (i == 15));
      send(2'b01, 1'b0, 1'b0);   // discarded in WAIT

      // 5: acquisition with idle gaps
      for (int i = 0; i < 64; i++) begin
         idle($urandom_range(0, 3));
         send(2'b01, (i == 63), 1'b0);
      end
      idle(2);

      // 6: reset mid-window drops lock; 63 valid + invalid 64th slips
      for (int i = 0; i < 20; i++) send(2'b10, 1'b1, 1'b0);
      do_reset();
      for (int i = 0; i < 63; i++) send(2'b01, 1'b0, 1'b0);
      send(2'b11, 1'b0, 1'b1);
      send(2'b10, 1'b0, 1'b0);
      for (int i = 0; i < 64; i++) send(2'b10, (i == 63), 1'b0);

      // 7: 64th header is also the 16th invalid: loss beats window end
      for (int i = 0; i < 48; i++) send(2'b01, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) send(2'b00, (i != 15), (i == 15));
      send(2'b00, 1'b0, 1'b0);   // discarded in WAIT, no second slip
      send(2'b01, 1'b0, 1'b0);

      idle(3);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected responses never seen", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
